// File: rtl/regfile_writeback.sv
// Register-file write-port front end: merges ALU results with buffered,
// extended load returns and tracks outstanding loads per destination register.
module regfile_writeback #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    alu_valid_i,
    input  logic [4:0]              alu_rd_i,
    input  logic [31:0]             alu_data_i,
    input  logic                    ld_issue_i,
    input  logic [4:0]              ld_issue_rd_i,
    input  logic                    ld_valid_i,
    output logic                    ld_ready_o,
    input  logic [4:0]              ld_rd_i,
    input  logic [31:0]             ld_data_i,
    input  logic [2:0]              ld_funct3_i,
    input  logic [1:0]              ld_off_i,
    output logic [31:0]             busy_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    wen_o,
    output logic [4:0]              waddr_o,
    output logic [31:0]             data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Byte/halfword select and sign/zero extension of a raw aligned word.
    function automatic logic [31:0] extend(input logic [31:0] word,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extend = {{24{b[7]}}, b};
            3'b001:  extend = {{16{h[15]}}, h};
            3'b100:  extend = {24'd0, b};
            3'b101:  extend = {16'd0, h};
            default: extend = word;
        endcase
    endfunction

    logic [4:0]       fifo_rd_q   [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      busy_q, busy_d;
    logic             wen_q, wen_d;
    logic [4:0]       waddr_q, waddr_d;
    logic [31:0]      data_q, data_d;
    logic             push_c;
    logic             pop_c;
    logic [4:0]       head_rd_c;
    logic [31:0]      head_data_c;

    // Accept only against the registered occupancy; no same-cycle pop credit.
    assign ld_ready_o = ~rst_i & (count_q < CNT_W'(DEPTH));

    // Arbitration, FIFO pointer/count update and scoreboard next state.
    always_comb begin
        push_c      = ld_valid_i & ld_ready_o;
        pop_c       = ~alu_valid_i & (count_q != '0);
        head_rd_c   = fifo_rd_q[rptr_q];
        head_data_c = fifo_data_q[rptr_q];

        wptr_d  = push_c ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop_c  ? rptr_q + PTR_W'(1) : rptr_q;
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

        wen_d   = 1'b0;
        waddr_d = waddr_q;
        data_d  = data_q;
        if (alu_valid_i) begin
            wen_d   = (alu_rd_i != 5'd0);
            waddr_d = alu_rd_i;
            data_d  = alu_data_i;
        end else if (pop_c) begin
            wen_d   = (head_rd_c != 5'd0);
            waddr_d = head_rd_c;
            data_d  = head_data_c;
        end

        // Clear on writeback first so a same-cycle re-issue wins.
        busy_d = busy_q;
        if (pop_c) begin
            busy_d[head_rd_c] = 1'b0;
        end
        if (ld_issue_i && (ld_issue_rd_i != 5'd0)) begin
            busy_d[ld_issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            data_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
        end
    end

    // FIFO storage; entries are extended on the way in.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            fifo_rd_q[wptr_q]   <= ld_rd_i;
            fifo_data_q[wptr_q] <= extend(ld_data_i, ld_funct3_i, ld_off_i);
        end
    end

    assign busy_o  = busy_q;
    assign count_o = count_q;
    assign wen_o   = wen_q;
    assign waddr_o = waddr_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed tables and sequences plus
// randomized traffic compared each cycle against a queue-based reference model.
module tb_regfile_writeback;

    localparam int unsigned DEPTH   = 4;
    localparam int          DEPTH_I = 4;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             alu_valid_i;
    logic [4:0]       alu_rd_i;
    logic [31:0]      alu_data_i;
    logic             ld_issue_i;
    logic [4:0]       ld_issue_rd_i;
    logic             ld_valid_i;
    logic             ld_ready_o;
    logic [4:0]       ld_rd_i;
    logic [31:0]      ld_data_i;
    logic [2:0]       ld_funct3_i;
    logic [1:0]       ld_off_i;
    logic [31:0]      busy_o;
    logic [CNT_W-1:0] count_o;
    logic             wen_o;
    logic [4:0]       waddr_o;
    logic [31:0]      data_o;

    always #5 clk_i = ~clk_i;

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .alu_valid_i  (alu_valid_i),
        .alu_rd_i     (alu_rd_i),
        .alu_data_i   (alu_data_i),
        .ld_issue_i   (ld_issue_i),
        .ld_issue_rd_i(ld_issue_rd_i),
        .ld_valid_i   (ld_valid_i),
        .ld_ready_o   (ld_ready_o),
        .ld_rd_i      (ld_rd_i),
        .ld_data_i    (ld_data_i),
        .ld_funct3_i  (ld_funct3_i),
        .ld_off_i     (ld_off_i),
        .busy_o       (busy_o),
        .count_o      (count_o),
        .wen_o        (wen_o),
        .waddr_o      (waddr_o),
        .data_o       (data_o)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    logic        m_wen   = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_data  = '0;
    logic [31:0] m_busy  = '0;

    int n_assert = 0;
    int n_fail   = 0;

    // Extension computed arithmetically: shift, mask, subtract for negatives.
    function automatic logic [31:0] ref_extend(input logic [31:0] w,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
        int unsigned v;
        int unsigned o;
        o = int'(off);
        case (f3)
            3'd0: begin
                v = (w >> (8 * o)) & 32'hFF;
                if (v >= 128) v = v - 256;
            end
            3'd1: begin
                v = (w >> (16 * (o / 2))) & 32'hFFFF;
                if (v >= 32768) v = v - 65536;
            end
            3'd4: v = (w >> (8 * o)) & 32'hFF;
            3'd5: v = (w >> (16 * (o / 2))) & 32'hFFFF;
            default: v = w;
        endcase
        return 32'(v);
    endfunction

    always @(posedge clk_i) begin : model
        ent_t        e;
        logic        acc;
        logic [31:0] clr;
        if (rst_i) begin
            m_q.delete();
            m_busy  = '0;
            m_wen   = 1'b0;
            m_waddr = '0;
            m_data  = '0;
        end else begin
            acc = ld_valid_i && (m_q.size() < DEPTH_I);
            clr = '0;
            if (alu_valid_i) begin
                m_wen   = (alu_rd_i != 0);
                m_waddr = alu_rd_i;
                m_data  = alu_data_i;
            end else if (m_q.size() > 0) begin
                e       = m_q.pop_front();
                m_wen   = (e.rd != 0);
                m_waddr = e.rd;
                m_data  = e.data;
                clr[e.rd] = 1'b1;
            end else begin
                m_wen = 1'b0;
            end
            if (acc) begin
                e.rd   = ld_rd_i;
                e.data = ref_extend(ld_data_i, ld_funct3_i, ld_off_i);
                m_q.push_back(e);
            end
            m_busy = m_busy & ~clr;
            if (ld_issue_i && ld_issue_rd_i != 0) m_busy[ld_issue_rd_i] = 1'b1;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance one clock, then compare every output against the model.
    task automatic tick();
        @(posedge clk_i);
        #1;
        chk("wen",   32'(wen_o),   32'(m_wen));
        chk("waddr", 32'(waddr_o), 32'(m_waddr));
        chk("data",  data_o,       m_data);
        chk("busy",  busy_o,       m_busy);
        chk("count", 32'(count_o), 32'(m_q.size()));
        chk("ready", 32'(ld_ready_o), 32'(!rst_i && (m_q.size() < DEPTH_I)));
    endtask

    task automatic idle();
        alu_valid_i   = 1'b0;
        alu_rd_i      = '0;
        alu_data_i    = '0;
        ld_issue_i    = 1'b0;
        ld_issue_rd_i = '0;
        ld_valid_i    = 1'b0;
        ld_rd_i       = '0;
        ld_data_i     = '0;
        ld_funct3_i   = '0;
        ld_off_i      = '0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 12; i++) tick();
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] exp;
    } ext_vec_t;

    ext_vec_t   vt[11];
    logic [4:0] got[$];
    logic [4:0] pend[$];

    initial begin : stim
        int   nxt;
        logic saw_full;
        logic hold;
        logic acc;
        logic [4:0] r;

        rst_i = 1'b1;
        idle();

        // Reset then idle
        tick();
        tick();
        chk("rst_wen",   32'(wen_o),   32'd0);
        chk("rst_waddr", 32'(waddr_o), 32'd0);
        chk("rst_data",  data_o,       32'd0);
        chk("rst_busy",  busy_o,       32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ready", 32'(ld_ready_o), 32'd0);
        rst_i = 1'b0;
        tick();
        chk("post_rst_ready", 32'(ld_ready_o), 32'd1);

        // ALU stream x1, x2, x0
        alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'h11;
        tick();
        chk("alu1_wen", 32'(wen_o), 32'd1);
        chk("alu1_addr", 32'(waddr_o), 32'd1);
        chk("alu1_data", data_o, 32'h11);
        alu_rd_i = 5'd2; alu_data_i = 32'h22;
        tick();
        chk("alu2_wen", 32'(wen_o), 32'd1);
        chk("alu2_addr", 32'(waddr_o), 32'd2);
        chk("alu2_data", data_o, 32'h22);
        alu_rd_i = 5'd0; alu_data_i = 32'h33;
        tick();
        chk("alu0_wen", 32'(wen_o), 32'd0);
        idle();
        tick();
        chk("alu_idle_wen", 32'(wen_o), 32'd0);

        // Load extension table
        vt[0]  = '{3'b000, 2'd0, 32'hFFFF_FF81};
        vt[1]  = '{3'b100, 2'd0, 32'h0000_0081};
        vt[2]  = '{3'b000, 2'd1, 32'h0000_007F};
        vt[3]  = '{3'b000, 2'd3, 32'hFFFF_FF80};
        vt[4]  = '{3'b001, 2'd2, 32'hFFFF_80F0};
        vt[5]  = '{3'b101, 2'd2, 32'h0000_80F0};
        vt[6]  = '{3'b010, 2'd0, 32'h80F0_7F81};
        vt[7]  = '{3'b001, 2'd3, 32'hFFFF_80F0};
        vt[8]  = '{3'b101, 2'd1, 32'h0000_7F81};
        vt[9]  = '{3'b111, 2'd1, 32'h80F0_7F81};
        vt[10] = '{3'b010, 2'd3, 32'h80F0_7F81};
        for (int i = 0; i < 11; i++) begin
            idle();
            ld_issue_i = 1'b1; ld_issue_rd_i = 5'd3;
            tick();
            idle();
            ld_valid_i = 1'b1; ld_rd_i = 5'd3; ld_data_i = 32'h80F0_7F81;
            ld_funct3_i = vt[i].f3; ld_off_i = vt[i].off;
            tick();
            idle();
            tick();
            chk($sformatf("ext%0d_wen", i), 32'(wen_o), 32'd1);
            chk($sformatf("ext%0d_data", i), data_o, vt[i].exp);
        end

        // Scoreboard on x5, including set-wins-over-clear
        idle();
        ld_issue_i = 1'b1; ld_issue_rd_i = 5'd5;
        tick();
        chk("sb_set", 32'(busy_o[5]), 32'd1);
        idle();
        tick();
        chk("sb_hold", 32'(busy_o[5]), 32'd1);
        ld_valid_i = 1'b1; ld_rd_i = 5'd5; ld_data_i = 32'hDEAD_0000; ld_funct3_i = 3'b010;
        tick();
        chk("sb_queued", 32'(busy_o[5]), 32'd1);
        chk("sb_queued_wen", 32'(wen_o), 32'd0);
        idle();
        tick();
        chk("sb_wb_wen", 32'(wen_o), 32'd1);
        chk("sb_wb_addr", 32'(waddr_o), 32'd5);
        chk("sb_wb_data", data_o, 32'hDEAD_0000);
        chk("sb_clear", 32'(busy_o[5]), 32'd0);
        ld_issue_i = 1'b1; ld_issue_rd_i = 5'd5;
        tick();
        idle();
        tick();
        ld_valid_i = 1'b1; ld_rd_i = 5'd5; ld_data_i = 32'h0000_1234; ld_funct3_i = 3'b010;
        tick();
        idle();
        ld_issue_i = 1'b1; ld_issue_rd_i = 5'd5;
        tick();
        chk("sb_sw_wen", 32'(wen_o), 32'd1);
        chk("sb_sw_data", data_o, 32'h0000_1234);
        chk("sb_set_wins", 32'(busy_o[5]), 32'd1);
        idle();
        ld_valid_i = 1'b1; ld_rd_i = 5'd5; ld_data_i = 32'h0000_5678; ld_funct3_i = 3'b010;
        tick();
        drain();
        chk("sb_final", 32'(busy_o[5]), 32'd0);

        // Arbitration and full FIFO
        for (int i = 1; i <= 5; i++) begin
            idle();
            ld_issue_i = 1'b1; ld_issue_rd_i = 5'(i);
            tick();
        end
        idle();
        nxt = 1;
        saw_full = 1'b0;
        got.delete();
        for (int c = 0; c < 40 && got.size() < 11; c++) begin
            alu_valid_i = (c < 6);
            alu_rd_i    = 5'(10 + c);
            alu_data_i  = 32'(100 + c);
            ld_valid_i  = (nxt <= 5);
            ld_rd_i     = 5'(nxt);
            ld_data_i   = 32'(nxt * 256);
            ld_funct3_i = 3'b010;
            acc = ld_valid_i && (m_q.size() < DEPTH_I);
            tick();
            if (acc) nxt++;
            if (c == 3) begin
                chk("full_count", 32'(count_o), 32'd4);
                chk("full_ready", 32'(ld_ready_o), 32'd0);
            end
            if (c == 5) begin
                chk("full_held_count", 32'(count_o), 32'd4);
                saw_full = (nxt == 5);
            end
            if (wen_o) got.push_back(waddr_o);
        end
        chk("full_5th_held", 32'(saw_full), 32'd1);
        chk("arb_nwrites", 32'(got.size()), 32'd11);
        for (int k = 0; k < 11; k++) begin
            if (k < got.size())
                chk($sformatf("arb_order%0d", k), 32'(got[k]), (k < 6) ? 32'(10 + k) : 32'(k - 5));
        end
        drain();

        // Reset mid-operation
        for (int i = 6; i <= 8; i++) begin
            idle();
            ld_issue_i = 1'b1; ld_issue_rd_i = 5'(i);
            tick();
        end
        for (int i = 6; i <= 8; i++) begin
            idle();
            alu_valid_i = 1'b1; alu_rd_i = 5'd20; alu_data_i = 32'(i);
            ld_valid_i = 1'b1; ld_rd_i = 5'(i); ld_data_i = 32'hCAFE_0000; ld_funct3_i = 3'b010;
            tick();
        end
        idle();
        chk("mid_pre_count", 32'(count_o), 32'd3);
        chk("mid_pre_busy", busy_o, 32'h0000_01C0);
        rst_i = 1'b1;
        tick();
        chk("mid_rst_wen", 32'(wen_o), 32'd0);
        chk("mid_rst_count", 32'(count_o), 32'd0);
        chk("mid_rst_busy", busy_o, 32'd0);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_post_wen", 32'(wen_o), 32'd0);
        end

        // Randomized traffic obeying the core's protocol obligations
        pend.delete();
        hold = 1'b0;
        idle();
        for (int c = 0; c < 3000; c++) begin
            rst_i = ($urandom_range(0, 299) == 0);
            if (!hold) begin
                ld_valid_i = 1'b0;
                if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                    ld_valid_i  = 1'b1;
                    ld_rd_i     = pend[0];
                    ld_data_i   = $urandom();
                    ld_funct3_i = 3'($urandom_range(0, 7));
                    ld_off_i    = 2'($urandom_range(0, 3));
                end
            end
            alu_valid_i = ($urandom_range(0, 2) == 0);
            alu_rd_i    = 5'($urandom_range(0, 31));
            alu_data_i  = $urandom();
            if (m_busy[alu_rd_i]) alu_valid_i = 1'b0;
            ld_issue_i = 1'b0;
            r = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0 && pend.size() < 6 && (r == 0 || !m_busy[r])) begin
                ld_issue_i    = 1'b1;
                ld_issue_rd_i = r;
            end
            acc = ld_valid_i && !rst_i && (m_q.size() < DEPTH_I);
            tick();
            if (rst_i) begin
                pend.delete();
                hold = 1'b0;
                ld_valid_i = 1'b0;
            end else begin
                if (ld_valid_i) begin
                    if (acc) begin
                        void'(pend.pop_front());
                        hold = 1'b0;
                    end else begin
                        hold = 1'b1;
                    end
                end
                if (ld_issue_i) pend.push_back(ld_issue_rd_i);
            end
        end
        rst_i = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
